// File: rtl/arith_engine.sv
// arith_engine: two-stage MIPS-subset integer engine with E-to-D forwarding and halt on illegal instructions
module arith_engine #(
  parameter int WIDTH = 32,
  parameter int NREG = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  output logic             inst_ready,
  output logic [31:0]      pc,
  output logic             except,
  output logic [31:0]      retired,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  typedef enum logic {RUN, HALT} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT} op_t;
  state_t state;
  logic [WIDTH-1:0] rf [32];
  logic e_valid;
  op_t e_op;
  logic [4:0] e_dst;
  logic [WIDTH-1:0] e_a, e_b, e_res;
  logic [5:0] opc, fn;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  op_t d_op;
  logic d_rtype, d_known, d_zext, d_legal, accept;
  logic [4:0] d_dst;
  logic [WIDTH-1:0] rs_val, rt_val, imm_ext;
  logic unused_shamt;
  assign {opc, rs, rt, rd} = inst[31:11];
  assign fn = inst[5:0];
  assign imm = inst[15:0];
  assign unused_shamt = ^inst[10:6];
  assign inst_ready = state == RUN;
  assign accept = inst_valid && inst_ready;
  // Map opcode/funct onto an ALU operation; anything unmatched is flagged unknown
  always_comb begin
    d_op = OP_ADD;
    d_rtype = opc == 6'h00;
    d_known = 1'b1;
    d_zext = 1'b0;
    if (d_rtype)
      case (fn)
        6'h20: d_op = OP_ADD;
        6'h22: d_op = OP_SUB;
        6'h24: d_op = OP_AND;
        6'h25: d_op = OP_OR;
        6'h26: d_op = OP_XOR;
        6'h27: d_op = OP_NOR;
        6'h2A: d_op = OP_SLT;
        default: d_known = 1'b0;
      endcase
    else
      case (opc)
        6'h08: d_op = OP_ADD;
        6'h0A: d_op = OP_SLT;
        6'h0C: {d_op, d_zext} = {OP_AND, 1'b1};
        6'h0D: {d_op, d_zext} = {OP_OR, 1'b1};
        6'h0E: {d_op, d_zext} = {OP_XOR, 1'b1};
        default: d_known = 1'b0;
      endcase
  end
  assign d_legal = d_known && {1'b0, rs} < 6'(NREG) && {1'b0, rt} < 6'(NREG) && (!d_rtype || {1'b0, rd} < 6'(NREG));
  assign d_dst = d_rtype ? rd : rt;
  assign imm_ext = WIDTH'($signed({imm[15] & ~d_zext, imm}));
  assign rs_val = (e_valid && e_dst != 5'd0 && e_dst == rs) ? e_res : rf[rs];
  assign rt_val = (e_valid && e_dst != 5'd0 && e_dst == rt) ? e_res : rf[rt];
  assign e_res = e_op == OP_ADD ? e_a + e_b :
                 e_op == OP_SUB ? e_a - e_b :
                 e_op == OP_AND ? e_a & e_b :
                 e_op == OP_OR  ? e_a | e_b :
                 e_op == OP_XOR ? e_a ^ e_b :
                 e_op == OP_NOR ? ~(e_a | e_b) :
                 {{(WIDTH-1){1'b0}}, $signed(e_a) < $signed(e_b)};
  assign dbg_data = (dbg_addr == 5'd0 || {1'b0, dbg_addr} >= 6'(NREG)) ? '0 : rf[dbg_addr];
  // FSM, pc/retired counters and the D-to-E pipeline register
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= RUN;
      pc <= '0;
      except <= 1'b0;
      retired <= '0;
      e_valid <= 1'b0;
      e_op <= OP_ADD;
      e_dst <= '0;
      e_a <= '0;
      e_b <= '0;
    end else begin
      e_valid <= accept && d_legal;
      if (accept) begin
        pc <= pc + 32'd4;
        e_op <= d_op;
        e_dst <= d_dst;
        e_a <= rs_val;
        e_b <= d_rtype ? rt_val : imm_ext;
      end
      if (accept && !d_legal) begin
        state <= HALT;
        except <= 1'b1;
      end
      if (e_valid) retired <= retired + 32'd1;
    end
  // Write-back; entry 0 and entries at or above NREG never change
  always_ff @(posedge clock or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else for (int i = 1; i < NREG; i++) if (e_valid && e_dst == 5'(i)) rf[i] <= e_res;
endmodule

// File: tb/tb_arith_engine.sv
// tb_arith_engine: vector table, directed corner sequences and randomized ISA-level model comparison
module tb_arith_engine;
  logic clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [4:0] dbg_addr = '0;
  logic inst_ready, except, inst_ready8, except8;
  logic [31:0] pc, retired, dbg_data, pc8, retired8, dbg_data8;
  int checks = 0, failures = 0;
  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_ret;
  logic m_exc;
  typedef struct {logic [31:0] inst; logic [4:0] dst; logic [31:0] exp;} vec_t;
  vec_t tv [21];

  always #5 clk = ~clk;

  arith_engine dut (.clock(clk), .reset(rst_n), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .except(except), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data));
  arith_engine #(.WIDTH(32), .NREG(8)) dut8 (.clock(clk), .reset(rst_n), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready8), .pc(pc8), .except(except8), .retired(retired8), .dbg_addr(dbg_addr), .dbg_data(dbg_data8));

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic do_reset();
    inst_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = '0;
    m_ret = '0;
    m_exc = 1'b0;
  endtask

  // ISA-level semantics: every accepted instruction takes effect at once on the architectural state
  task automatic m_accept(input logic [31:0] i);
    logic [31:0] a, b, se, ze, val;
    logic [4:0] dst;
    logic ok;
    a = m_rf[i[25:21]];
    b = m_rf[i[20:16]];
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    ok = 1'b1;
    val = '0;
    dst = (i[31:26] == 6'h00) ? i[15:11] : i[20:16];
    if (i[31:26] == 6'h00)
      case (i[5:0])
        6'h20: val = a + b;
        6'h22: val = a - b;
        6'h24: val = a & b;
        6'h25: val = a | b;
        6'h26: val = a ^ b;
        6'h27: val = ~(a | b);
        6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: ok = 1'b0;
      endcase
    else
      case (i[31:26])
        6'h08: val = a + se;
        6'h0A: val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0C: val = a & ze;
        6'h0D: val = a | ze;
        6'h0E: val = a ^ ze;
        default: ok = 1'b0;
      endcase
    m_pc = m_pc + 32'd4;
    if (!ok) m_exc = 1'b1;
    else begin
      m_ret = m_ret + 32'd1;
      if (dst != 5'd0) m_rf[dst] = val;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [5:0] ops [5] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    int k = $urandom_range(0, 11);
    if ($urandom_range(0, 79) == 0) return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : r_ins(rs, rt, rd, 6'h21);
    return (k < 7) ? r_ins(rs, rt, rd, fns[k]) : i_ins(ops[k-7], rs, rd, imm);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic acc;
    tv[0]  = '{i_ins(6'h08, 0, 1, 16'hFFFF), 5'd1, 32'hFFFFFFFF};
    tv[1]  = '{r_ins(1, 1, 2, 6'h20), 5'd2, 32'hFFFFFFFE};
    tv[2]  = '{i_ins(6'h0D, 0, 3, 16'hFFFF), 5'd3, 32'h0000FFFF};
    tv[3]  = '{i_ins(6'h0A, 3, 4, 16'h0000), 5'd4, 32'h00000000};
    tv[4]  = '{i_ins(6'h08, 0, 5, 16'hFFFB), 5'd5, 32'hFFFFFFFB};
    tv[5]  = '{r_ins(5, 0, 6, 6'h2A), 5'd6, 32'h00000001};
    tv[6]  = '{r_ins(0, 1, 7, 6'h22), 5'd7, 32'h00000001};
    tv[7]  = '{r_ins(3, 5, 8, 6'h24), 5'd8, 32'h0000FFFB};
    tv[8]  = '{r_ins(3, 5, 9, 6'h25), 5'd9, 32'hFFFFFFFF};
    tv[9]  = '{r_ins(3, 5, 10, 6'h26), 5'd10, 32'hFFFF0004};
    tv[10] = '{r_ins(3, 5, 11, 6'h27), 5'd11, 32'h00000000};
    tv[11] = '{i_ins(6'h0C, 1, 12, 16'h8001), 5'd12, 32'h00008001};
    tv[12] = '{i_ins(6'h0E, 1, 13, 16'h8000), 5'd13, 32'hFFFF7FFF};
    tv[13] = '{i_ins(6'h08, 0, 14, 16'h7FFF), 5'd14, 32'h00007FFF};
    tv[14] = '{i_ins(6'h08, 14, 15, 16'h8000), 5'd15, 32'hFFFFFFFF};
    tv[15] = '{r_ins(5, 1, 16, 6'h22), 5'd16, 32'hFFFFFFFC};
    tv[16] = '{r_ins(1, 1, 0, 6'h20), 5'd0, 32'h00000000};
    tv[17] = '{r_ins(0, 5, 17, 6'h2A), 5'd17, 32'h00000000};
    tv[18] = '{i_ins(6'h0A, 5, 18, 16'hFFFC), 5'd18, 32'h00000001};
    tv[19] = '{i_ins(6'h08, 1, 19, 16'h0001), 5'd19, 32'h00000000};
    tv[20] = '{i_ins(6'h0D, 1, 20, 16'h0000), 5'd20, 32'hFFFFFFFF};

    // Reset state
    do_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_except", {31'd0, except}, 32'd0);
    chk("rst_ready", {31'd0, inst_ready}, 32'd1);
    rd(5'd1, v);
    chk("rst_r1", v, 32'd0);

    // Back-to-back vector table; each result checked the cycle after its write edge
    inst_valid = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      if (k < 21) inst = tv[k].inst;
      else inst_valid = 1'b0;
      tick();
      if (k > 0) begin
        rd(tv[k-1].dst, v);
        chk($sformatf("vec%0d", k - 1), v, tv[k-1].exp);
      end
    end
    chk("vec_retired", retired, 32'd21);
    chk("vec_pc", pc, 32'd84);

    // Illegal opcode after a legal one, then HALT holds despite valid input
    do_reset();
    inst = i_ins(6'h08, 0, 1, 16'd1);
    inst_valid = 1'b1;
    tick();
    inst = 32'hFC000000;
    tick();
    inst = i_ins(6'h08, 1, 1, 16'd5);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("halt_pc", pc, 32'd8);
      chk("halt_ready", {31'd0, inst_ready}, 32'd0);
      chk("halt_except", {31'd0, except}, 32'd1);
    end
    inst_valid = 1'b0;
    chk("halt_retired", retired, 32'd1);
    rd(5'd1, v);
    chk("halt_r1", v, 32'd1);

    // Register field beyond NREG on the 8-register instance
    do_reset();
    inst = i_ins(6'h08, 0, 9, 16'd1);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    chk("n8_except", {31'd0, except8}, 32'd1);
    chk("n8_ready", {31'd0, inst_ready8}, 32'd0);
    chk("n8_retired", retired8, 32'd0);
    chk("n8_pc", pc8, 32'd4);
    chk("n32_retired", retired, 32'd1);
    rd(5'd9, v);
    chk("n32_r9", v, 32'd1);
    chk("n8_r9", dbg_data8, 32'd0);
    for (int a = 1; a < 8; a++) begin
      rd(5'(a), v);
      chk($sformatf("n8_r%0d", a), dbg_data8, 32'd0);
    end

    // Gapped issue: retired moves only on commit edges
    do_reset();
    inst = i_ins(6'h08, 0, 7, 16'd3);
    inst_valid = 1'b1;
    tick();
    chk("gap_ret_a", retired, 32'd0);
    inst_valid = 1'b0;
    tick();
    chk("gap_ret_b", retired, 32'd1);
    inst = i_ins(6'h08, 7, 7, 16'd4);
    inst_valid = 1'b1;
    tick();
    chk("gap_ret_c", retired, 32'd1);
    inst_valid = 1'b0;
    tick();
    chk("gap_ret_d", retired, 32'd2);
    rd(5'd7, v);
    chk("gap_r7", v, 32'd7);

    // Reset asserted between D and E discards the in-flight write
    do_reset();
    inst = i_ins(6'h08, 0, 2, 16'd9);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_pc", pc, 32'd0);
    chk("mid_retired", retired, 32'd0);
    chk("mid_except", {31'd0, except}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_ready", {31'd0, inst_ready}, 32'd1);
    tick();
    chk("mid_retired2", retired, 32'd0);
    rd(5'd2, v);
    chk("mid_r2", v, 32'd0);

    // Randomized rounds against the ISA-level model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        inst = rand_inst();
        inst_valid = $urandom_range(0, 3) != 0;
        acc = inst_valid && !m_exc;
        tick();
        if (acc) m_accept(inst);
        chk("rnd_pc", pc, m_pc);
        chk("rnd_ready", {31'd0, inst_ready}, {31'd0, !m_exc});
        chk("rnd_except", {31'd0, except}, {31'd0, m_exc});
      end
      inst_valid = 1'b0;
      tick();
      chk("rnd_retired", retired, m_ret);
      for (int a = 0; a < 32; a++) begin
        rd(5'(a), v);
        chk($sformatf("rnd%0d_r%0d", r, a), v, m_rf[a]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arith_engine.md
ARITH_ENGINE -- requirements
Module: arith_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath and register width in bits; legal range 16..64.
REQ-002 SHALL have parameter NREG, default 32, meaning number of architectural registers; legal range 2..32.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inst  input  32  MIPS-encoded instruction word.
REQ-006 SHALL have port inst_valid  input  1  inst holds an instruction offered this cycle.
REQ-007 SHALL have port inst_ready  output  1  engine accepts inst this cycle.
REQ-008 SHALL have port pc  output  32  byte address of the next instruction to be accepted.
REQ-009 SHALL have port except  output  1  sticky flag: an unrecognised instruction was accepted.
REQ-010 SHALL have port retired  output  32  count of committed instructions.
REQ-011 SHALL have port dbg_addr  input  5  register index for debug read.
REQ-012 SHALL have port dbg_data  output  WIDTH  combinational register-file value at dbg_addr; 0 if dbg_addr is 0 or >= NREG.

Function
REQ-013 SHALL implement FSM states RUN and HALT; inst_ready = 1 exactly in RUN.
REQ-014 SHALL accept an instruction on a cycle with inst_valid && inst_ready; pc SHALL then advance by 4, wrapping modulo 2^32.
REQ-015 SHALL be a 2-stage pipeline: decode/register-read in the accept cycle (D), execute/writeback in the following cycle (E); result visible in the register file after the E-cycle edge.
REQ-016 SHALL recognise R-type (opcode 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A; destination rd.
REQ-017 SHALL recognise I-type addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, xori 0x0E; destination rt.
REQ-018 SHALL sign-extend imm16 to WIDTH for addi/slti; zero-extend for andi/ori/xori.
REQ-019 SHALL wrap add/sub results modulo 2^WIDTH with no overflow trap; slt/slti SHALL produce signed compare result 1 or 0, zero-extended.
REQ-020 SHALL treat register 0 as reading 0, with writes to it discarded.
REQ-021 SHALL forward the E-stage result to a D-stage operand when the E stage writes a nonzero rd equal to D's rs or rt, so back-to-back dependent instructions need no stall.
REQ-022 SHALL treat any other opcode/funct, or any used register field >= NREG, as illegal.
REQ-023 SHALL, on accepting an illegal instruction: perform no register write and no retired increment for it; set except and enter HALT at that edge; still let the older instruction in E complete.
REQ-024 SHALL keep pc frozen, leave inst_valid ignored, and hold except = 1 in HALT until reset.
REQ-025 SHALL increment retired by 1 at each E-stage commit of a legal instruction, including writes to register 0, wrapping modulo 2^32.
REQ-026 SHALL leave the E stage empty on cycles with no accept, with no commit and no forwarding source.
REQ-027 SHALL return the post-write value on dbg_data when dbg_addr names the register being written, starting the cycle after the edge.

Reset
REQ-028 SHALL, while reset = 0, asynchronously force: pc = 0, except = 0, retired = 0, all registers = 0, E stage empty, FSM = RUN.
REQ-029 SHALL discard an instruction in flight when reset asserts mid-operation, leaving no register write.
REQ-030 SHALL set inst_ready = 1 on the first rising clock edge after reset deasserts.

Verification
REQ-031 SHALL cover: addi $1,$0,-1 then add $2,$1,$1 back-to-back -> $2 = 0xFFFFFFFE at WIDTH=32, retired = 2, pc = 8.
REQ-032 SHALL cover: ori $3,$0,0xFFFF; slti $4,$3,0 -> $3 = 0x0000FFFF, $4 = 0; addi $5,$0,-5; slt $6,$5,$0 -> $6 = 1.
REQ-033 SHALL cover: addi $1,$0,1 followed by opcode 0x3F -> $1 = 1, retired = 1, except = 1, inst_ready = 0, pc = 8 held for 10 cycles.
REQ-034 SHALL cover: NREG=8, addi $9,$0,1 -> except = 1, no register changes.
REQ-035 SHALL cover: inst_valid toggling 1,0,1 with addi $7,$0,3 then addi $7,$7,4 -> $7 = 7, and retired increments only on commit cycles.
REQ-036 SHALL cover: reset pulled low between the D and E cycles of addi $2,$0,9 -> $2 = 0, pc = 0, retired = 0, except = 0.
